// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: fetches into an internal IR, steps DECODE/EXEC/MEM/WB,
// drives the shared datapath control bundle and counts retired instructions.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_i,
  input  logic        instr_valid_i,
  input  logic        dmem_ready_i,
  input  logic        br_taken_i,
  output logic        imem_req_o,
  output logic        dmem_req_o,
  output logic        ir_wr_o,
  output logic        pc_wr_o,
  output logic        pc_sel_o,
  output logic        RUWr,
  output logic [3:0]  ALUOp,
  output logic [2:0]  ImmSrc,
  output logic        ALUASrc,
  output logic        ALUBSrc,
  output logic        DMWr,
  output logic [2:0]  DMCtrl,
  output logic [4:0]  BrOp,
  output logic [1:0]  RUDataWrSrc,
  output logic        illegal_o,
  output logic [31:0] instret_o,
  output logic [2:0]  state_o
);

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   ir_q, ir_d;
  logic [XLEN-1:0]   instret_q, instret_d;
  logic              illegal_q, illegal_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_r, is_ialu, is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc;
  logic       is_legal, is_jump, in_decode_window;
  logic       unused_ir;

  assign opcode    = ir_q[6:0];
  assign funct3    = ir_q[14:12];
  assign unused_ir = ^{ir_q[31], ir_q[29:15], ir_q[11:7]};

  assign is_r      = (opcode == OP_R);
  assign is_ialu   = (opcode == OP_IALU);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);
  assign is_lui    = (opcode == OP_LUI);
  assign is_auipc  = (opcode == OP_AUIPC);
  assign is_jump   = is_jal | is_jalr;
  assign is_legal  = is_r | is_ialu | is_load | is_store | is_branch | is_jump | is_lui | is_auipc;

  assign in_decode_window = (state_q == S_DECODE) || (state_q == S_EXEC) ||
                            (state_q == S_MEM)    || (state_q == S_WB);

  // Datapath control fields, decoded from the IR only while an instruction is in flight.
  always_comb begin
    ALUOp       = 4'b0000;
    ImmSrc      = 3'b000;
    ALUASrc     = 1'b0;
    ALUBSrc     = 1'b0;
    DMCtrl      = 3'b000;
    BrOp        = 5'b00000;
    RUDataWrSrc = 2'b00;
    if (in_decode_window && is_legal) begin
      ALUBSrc = !is_r;
      ALUASrc = is_auipc | is_jal | is_branch;
      if (is_r)         ALUOp = {ir_q[30], funct3};
      else if (is_ialu) ALUOp = {ir_q[30] & (funct3 == 3'b101), funct3};
      else if (is_lui)  ALUOp = 4'b1111;
      if (is_store)                 ImmSrc = 3'b001;
      else if (is_lui || is_auipc)  ImmSrc = 3'b010;
      else if (is_branch)           ImmSrc = 3'b101;
      else if (is_jal)              ImmSrc = 3'b110;
      if (is_load || is_store) DMCtrl = funct3;
      if (is_branch)    BrOp = {2'b10, funct3};
      else if (is_jump) BrOp = 5'b00100;
      if (is_load)      RUDataWrSrc = 2'b01;
      else if (is_jump) RUDataWrSrc = 2'b10;
    end
  end

  // Sequencer: next state, IR load and handshake/commit strobes.
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    imem_req_o = 1'b0;
    dmem_req_o = 1'b0;
    ir_wr_o    = 1'b0;
    pc_wr_o    = 1'b0;
    pc_sel_o   = 1'b0;
    RUWr       = 1'b0;
    DMWr       = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req_o = 1'b1;
        if (instr_valid_i) begin
          ir_wr_o = 1'b1;
          ir_d    = instr_i;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = is_legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (is_load || is_store) begin
          state_d = S_MEM;
        end else if (is_branch) begin
          pc_wr_o  = 1'b1;
          pc_sel_o = br_taken_i;
          state_d  = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req_o = 1'b1;
        DMWr       = is_store;
        if (dmem_ready_i) begin
          if (is_store) begin
            pc_wr_o = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        RUWr     = 1'b1;
        pc_wr_o  = 1'b1;
        pc_sel_o = is_jump;
        state_d  = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    instret_d = instret_q + XLEN'(pc_wr_o);
    illegal_d = illegal_q | (state_d == S_TRAP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      ir_q      <= '0;
      instret_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
    end
  end

  assign illegal_o = illegal_q;
  assign instret_o = instret_q;
  assign state_o   = state_q;

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencer for the RV32I datapath: fetches an instruction over a request/valid port, latches it, and steps through DECODE/EXEC/MEM/WB states. It drives the same control bundle as the single-cycle control unit (RUWr, ALUOp, ImmSrc, ALUASrc, ALUBSrc, DMWr, DMCtrl, BrOp, RUDataWrSrc), adding PC/IR write enables and memory handshakes. It sits between the instruction/data memories and the shared datapath, and counts retired instructions.

## Interface
- no parameters; the instruction width is fixed at 32.
- clk  in  1  system clock; everything updates on its rising edge.
- rst  in  1  asynchronous reset, active-high.
- instr_i  in  32  fetched instruction; sampled only in FETCH.
- instr_valid_i  in  1  instr_i is valid this cycle.
- dmem_ready_i  in  1  data memory has completed the access.
- br_taken_i  in  1  branch comparator result, valid in EXEC.
- imem_req_o  out  1  instruction fetch request.
- dmem_req_o  out  1  data memory access request.
- ir_wr_o  out  1  load the instruction register.
- pc_wr_o  out  1  update the PC (commit strobe).
- pc_sel_o  out  1  0 selects PC+4, 1 selects ALU result.
- RUWr  out  1  register-file write enable.
- ALUOp  out  4  ALU operation.
- ImmSrc  out  3  immediate format.
- ALUASrc  out  1  0 selects rs1, 1 selects PC.
- ALUBSrc  out  1  0 selects rs2, 1 selects immediate.
- DMWr  out  1  data-memory write enable.
- DMCtrl  out  3  access size/sign (Funct3).
- BrOp  out  5  branch operation.
- RUDataWrSrc  out  2  writeback source: 00 ALU, 01 DM, 10 PC+4.
- illegal_o  out  1  sticky illegal-opcode flag.
- instret_o  out  32  count of retired instructions.
- state_o  out  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.

## Operation
- The internal IR (32 bits) loads instr_i whenever ir_wr_o=1. All decode comes from the IR, never from instr_i directly.
- Supported opcodes:
  - R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011.
  - BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
  - Any other opcode is illegal.
- Decoded fields, driven from the IR in DECODE, EXEC, MEM and WB (all zero in FETCH and TRAP):
  - ALUOp:
    - R-type: {IR[30], Funct3}.
    - I-ALU: {IR[30] & (Funct3==101), Funct3}.
    - LUI: 4'b1111, pass B.
    - All others: 4'b0000, add.
  - ImmSrc:
    - I-type, LOAD, JALR: 000.
    - STORE: 001.
    - LUI, AUIPC: 010.
    - BRANCH: 101.
    - JAL: 110.
  - ALUASrc=1 for AUIPC, JAL and BRANCH.
  - ALUBSrc=1 for every opcode except R-type.
  - DMCtrl = Funct3 for LOAD and STORE, else 000.
  - BrOp:
    - BRANCH: {2'b10, Funct3}.
    - JAL, JALR: 5'b00100.
    - All others: 00000.
  - RUDataWrSrc: LOAD 01, JAL/JALR 10, else 00.
- State transitions and strobes:
  - FETCH:
    - imem_req_o=1.
    - When instr_valid_i: ir_wr_o=1, go to DECODE. Otherwise stay.
  - DECODE: go to TRAP if the opcode is illegal, else to EXEC.
  - EXEC:
    - LOAD/STORE: go to MEM.
    - BRANCH: pc_wr_o=1, pc_sel_o=br_taken_i, go to FETCH.
    - All others: go to WB.
  - MEM:
    - dmem_req_o=1, and DMWr=1 for STORE. Both are held until dmem_ready_i.
    - On ready, STORE: pc_wr_o=1, pc_sel_o=0, go to FETCH.
    - On ready, LOAD: go to WB.
  - WB:
    - RUWr=1, pc_wr_o=1, go to FETCH.
    - pc_sel_o=1 for JAL/JALR, else 0.
  - TRAP:
    - illegal_o=1; all strobes and requests are 0.
    - Stays in TRAP until rst.
- instret_o increments by 1 on every cycle with pc_wr_o=1. It wraps from 0xFFFFFFFF to 0.
- Inputs outside their consuming state are ignored:
  - instr_valid_i outside FETCH.
  - dmem_ready_i outside MEM.
  - br_taken_i outside EXEC with BRANCH.

## Timing
- Reset (asynchronous, immediate):
  - state=FETCH, IR=0, instret_o=0, illegal_o=0.
  - All strobes and decoded outputs are 0, except imem_req_o=1 because the state is FETCH.
- Strobes (ir_wr_o, pc_wr_o, RUWr, DMWr, dmem_req_o) are decoded combinationally from state, IR and handshake inputs. They are high for exactly the cycle(s) listed under Operation.
- Minimum latency, counted from FETCH with instr_valid_i=1 to the return to FETCH:
  - BRANCH: 3 cycles.
  - R, I-ALU, LUI, AUIPC, JAL, JALR: 4 cycles.
  - STORE: 4 cycles (plus MEM wait).
  - LOAD: 5 cycles (plus MEM wait).
- Every extra cycle with instr_valid_i=0 or dmem_ready_i=0 adds one cycle. There is no timeout.
- Reset asserted mid-instruction abandons the instruction without committing: no RUWr, no pc_wr_o, no instret change.

## Test plan
- Reset → state_o=0, imem_req_o=1, instret_o=0. Then 0x002081B3 (add x3,x1,x2) with valid:
  - ir_wr_o pulses once.
  - In WB: RUWr=1, ALUOp=0000, ALUBSrc=0, pc_wr_o=1.
  - 4 cycles total; instret_o=1.
- Load 0x0040A183 (lw), with dmem_ready_i held low for 3 MEM cycles:
  - dmem_req_o high for 4 cycles, DMWr=0, DMCtrl=010.
  - WB follows with RUDataWrSrc=01; 8 cycles total.
- Store 0x0020A223 (sw):
  - In MEM: DMWr=1, ImmSrc=001, dmem_req_o=1.
  - Commit on ready with RUWr never asserted.
- Branch 0x00208463 (beq) with br_taken_i=1, then again with 0:
  - In EXEC: BrOp=10000, pc_wr_o=1, pc_sel_o=1 then 0 respectively.
  - 3 cycles each.
- Opcode 0x0000007F:
  - TRAP after DECODE; illegal_o=1 and stays set over 10 cycles.
  - No strobes, instret_o unchanged; rst clears it.
- Preload instret to 0xFFFFFFFF (via 2^32 commits or force), then one commit → instret_o=0. Assert rst during MEM of a store → no DMWr after rst, state_o=0.
